// File: rtl/cpu_types_pkg.sv
// Shared types for the memory stage: data word, FSM state and decoded access kind.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  localparam int WORD_AW = 30;
  typedef logic [WORD_AW-1:0] waddr_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } memstate_t;

  typedef struct packed {
    logic rd;
    logic wr;
    logic ll;
    logic sc;
  } memop_t;

  // Store beats load when both are set; LL only qualifies a load, SC only a store.
  function automatic memop_t decode_op(input logic dren, input logic dwen,
                                       input logic ll, input logic sc);
    memop_t op;
    op.wr = dwen;
    op.rd = dren & ~dwen;
    op.ll = ll & dren & ~dwen;
    op.sc = sc & dwen;
    return op;
  endfunction

endpackage

// File: rtl/mem_stage_link_reg.sv
// LL/SC reservation: one word address plus a valid bit, dropped by SC or a
// snooped store to the reserved word.
module link_reg
  import cpu_types_pkg::*;
(
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 i_set,
  input  logic [WORD_AW-1:0]   i_set_addr,
  input  logic                 i_clear,
  input  logic                 i_snoop_valid,
  input  logic [WORD_AW-1:0]   i_snoop_addr,
  input  logic [WORD_AW-1:0]   i_check_addr,
  output logic                 o_link_valid,
  output logic                 o_match
);

  logic               r_valid;
  logic [WORD_AW-1:0] r_addr;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_valid <= 1'b0;
      r_addr  <= '0;
    end else if (i_set) begin
      r_valid <= 1'b1;
      r_addr  <= i_set_addr;
    end else if (i_clear || (i_snoop_valid && (i_snoop_addr == r_addr))) begin
      r_valid <= 1'b0;
    end
  end

  assign o_link_valid = r_valid;
  assign o_match      = (r_addr == i_check_addr);

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: turns EX/MEM load/store controls into a registered cache
// request, stalls upstream until dhit, and handles LL/SC and a cache timeout.
module mem_stage
  import cpu_types_pkg::*;
#(
  parameter int MAX_WAIT = 255
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        mem_valid,
  input  logic        dren_in,
  input  logic        dwen_in,
  input  logic        ll_in,
  input  logic        sc_in,
  input  logic [31:0] addr_in,
  input  logic [31:0] store_in,
  input  logic        dhit,
  input  logic [31:0] dmemload,
  output logic        dmemREN,
  output logic        dmemWEN,
  output logic [31:0] dmemaddr,
  output logic [31:0] dmemstore,
  output logic        mem_stall,
  output logic [31:0] load_out,
  output logic        load_valid,
  output logic        sc_result,
  output logic        err_out
);

  localparam int CW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_WAIT - 1);

  memstate_t r_state, w_next;
  memop_t    w_op, r_op;

  logic          r_ren, r_wen;
  word_t         r_addr, r_store;
  word_t         r_load_out;
  logic          r_load_valid, r_sc_result, r_err;
  logic [CW-1:0] r_cnt;

  logic w_accept, w_launch, w_sc_fail, w_hit_done, w_timeout, w_req_miss, w_stall;
  logic w_link_valid, w_link_match, w_link_ok;
  logic w_link_set, w_link_clr, w_snoop;

  assign w_op      = decode_op(dren_in, dwen_in, ll_in, sc_in);
  assign w_accept  = mem_valid & (dren_in | dwen_in);
  assign w_link_ok = w_link_valid & w_link_match;

  // IDLE: wait for an access | REQ: request held until dhit or timeout | DONE: one-cycle result
  always_ff @(posedge CLK) begin
    if (RST) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_stall    = 1'b0;
    w_launch   = 1'b0;
    w_sc_fail  = 1'b0;
    w_hit_done = 1'b0;
    w_timeout  = 1'b0;
    w_req_miss = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_stall = 1'b1;
          if (w_op.sc && !w_link_ok) begin
            w_sc_fail = 1'b1;
            w_next    = DONE;
          end else begin
            w_launch = 1'b1;
            w_next   = REQ;
          end
        end
      end
      REQ: begin
        w_stall = 1'b1;
        if (dhit) begin
          w_hit_done = 1'b1;
          w_next     = DONE;
        end else if (r_cnt == CNT_LAST) begin
          w_timeout = 1'b1;
          w_next    = DONE;
        end else begin
          w_req_miss = 1'b1;
        end
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_op         <= '0;
      r_ren        <= 1'b0;
      r_wen        <= 1'b0;
      r_addr       <= '0;
      r_store      <= '0;
      r_load_out   <= '0;
      r_load_valid <= 1'b0;
      r_sc_result  <= 1'b0;
      r_err        <= 1'b0;
      r_cnt        <= '0;
    end else begin
      // result outputs live for the single DONE cycle only
      r_load_out   <= '0;
      r_load_valid <= 1'b0;
      r_sc_result  <= 1'b0;
      if (w_launch) begin
        r_op    <= w_op;
        r_ren   <= w_op.rd;
        r_wen   <= w_op.wr;
        r_addr  <= addr_in;
        r_store <= store_in;
        r_cnt   <= '0;
      end
      if (w_sc_fail) begin
        r_load_valid <= 1'b1;
      end
      if (w_hit_done || w_timeout) begin
        r_ren        <= 1'b0;
        r_wen        <= 1'b0;
        r_addr       <= '0;
        r_store      <= '0;
        r_load_valid <= r_op.rd | r_op.sc;
      end
      if (w_hit_done) begin
        r_sc_result <= r_op.sc;
        if (r_op.sc)      r_load_out <= 32'd1;
        else if (r_op.rd) r_load_out <= dmemload;
      end
      if (w_timeout) begin
        r_err <= 1'b1;
      end
      if (w_req_miss) begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign w_link_set = w_hit_done & r_op.ll;
  assign w_link_clr = (w_hit_done & r_op.sc) | w_sc_fail;
  assign w_snoop    = w_hit_done & r_op.wr & ~r_op.sc;

  link_reg u_link_reg (
    .CLK           (CLK),
    .RST           (RST),
    .i_set         (w_link_set),
    .i_set_addr    (r_addr[31:2]),
    .i_clear       (w_link_clr),
    .i_snoop_valid (w_snoop),
    .i_snoop_addr  (r_addr[31:2]),
    .i_check_addr  (addr_in[31:2]),
    .o_link_valid  (w_link_valid),
    .o_match       (w_link_match)
  );

  assign dmemREN    = r_ren;
  assign dmemWEN    = r_wen;
  assign dmemaddr   = r_addr;
  assign dmemstore  = r_store;
  assign mem_stall  = w_stall;
  assign load_out   = r_load_out;
  assign load_valid = r_load_valid;
  assign sc_result  = r_sc_result;
  assign err_out    = r_err;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed vector table, reset/LLSC sequences, and random
// accesses checked against a transaction-level model of stall count, results and link.
module tb_mem_stage;

  localparam int MW = 4;

  logic        CLK = 1'b0;
  logic        RST;
  logic        mem_valid, dren_in, dwen_in, ll_in, sc_in, dhit;
  logic [31:0] addr_in, store_in, dmemload;
  logic        dmemREN, dmemWEN, mem_stall, load_valid, sc_result, err_out;
  logic [31:0] dmemaddr, dmemstore, load_out;

  always #5 CLK = ~CLK;

  mem_stage #(.MAX_WAIT(MW)) dut (
    .CLK(CLK), .RST(RST), .mem_valid(mem_valid), .dren_in(dren_in), .dwen_in(dwen_in),
    .ll_in(ll_in), .sc_in(sc_in), .addr_in(addr_in), .store_in(store_in), .dhit(dhit),
    .dmemload(dmemload), .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr),
    .dmemstore(dmemstore), .mem_stall(mem_stall), .load_out(load_out),
    .load_valid(load_valid), .sc_result(sc_result), .err_out(err_out)
  );

  int n_chk = 0;
  int n_fail = 0;

  logic        m_err;
  logic        m_link_v;
  logic [29:0] m_link_a;

  typedef struct {
    logic        rd, wr, ll, sc;
    logic [31:0] addr, data;
    int          hd;
    logic [31:0] rdata;
    int          xs;
    logic        xlv;
    logic [31:0] xlo;
    logic        xsc;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mkv(logic rd, logic wr, logic ll, logic sc, logic [31:0] addr,
                               logic [31:0] data, int hd, logic [31:0] rdata, int xs,
                               logic xlv, logic [31:0] xlo, logic xsc);
    vec_t v;
    v.rd = rd; v.wr = wr; v.ll = ll; v.sc = sc; v.addr = addr; v.data = data;
    v.hd = hd; v.rdata = rdata; v.xs = xs; v.xlv = xlv; v.xlo = xlo; v.xsc = xsc;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_chk++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, want, $time);
    end
  endtask

  task automatic clear_inputs();
    mem_valid = 0; dren_in = 0; dwen_in = 0; ll_in = 0; sc_in = 0;
    addr_in = 0; store_in = 0; dhit = 0; dmemload = 0;
  endtask

  // One access. xs is the expected number of stall cycles; the DONE cycle is cycle xs.
  task automatic do_op(input logic rd, input logic wr, input logic ll, input logic sc,
                       input logic [31:0] addr, input logic [31:0] data, input int hd,
                       input logic [31:0] rdata, input int xs, input logic xlv,
                       input logic [31:0] xlo, input logic xsc, input logic noise,
                       input string nm);
    logic to, xr, in_req;
    to = (xs >= 2) && (hd + 1 >= xs);
    xr = rd & ~wr;
    mem_valid = 1; dren_in = rd; dwen_in = wr; ll_in = ll; sc_in = sc;
    addr_in = addr; store_in = data; dmemload = rdata;
    for (int c = 0; c <= xs; c++) begin
      dhit = ((c == hd + 1) && (c < xs)) || ((c == xs) && noise);
      @(negedge CLK);
      if (c == xs && to) m_err = 1'b1;
      in_req = (c >= 1) && (c < xs);
      chk({nm, " stall"}, {31'd0, mem_stall}, {31'd0, c < xs});
      chk({nm, " ren"}, {31'd0, dmemREN}, {31'd0, in_req & xr});
      chk({nm, " wen"}, {31'd0, dmemWEN}, {31'd0, in_req & wr});
      if (in_req) chk({nm, " addr"}, dmemaddr, addr);
      if (in_req && wr) chk({nm, " store"}, dmemstore, data);
      chk({nm, " err"}, {31'd0, err_out}, {31'd0, m_err});
      if (c == xs) begin
        chk({nm, " load_valid"}, {31'd0, load_valid}, {31'd0, xlv});
        chk({nm, " load_out"}, load_out, xlo);
        chk({nm, " sc_result"}, {31'd0, sc_result}, {31'd0, xsc});
      end else begin
        chk({nm, " early load_valid"}, {31'd0, load_valid}, 32'd0);
      end
      @(posedge CLK); #1;
    end
    clear_inputs();
    @(negedge CLK);
    chk({nm, " post stall"}, {31'd0, mem_stall}, 32'd0);
    chk({nm, " post req"}, {30'd0, dmemREN, dmemWEN}, 32'd0);
    chk({nm, " post load_valid"}, {31'd0, load_valid}, 32'd0);
    @(posedge CLK); #1;
  endtask

  task automatic idle_check(input logic mv, input logic rd, input logic wr, input string nm);
    mem_valid = mv; dren_in = rd; dwen_in = wr; addr_in = 32'h1000; dhit = 1'b1;
    @(negedge CLK);
    chk({nm, " stall"}, {31'd0, mem_stall}, 32'd0);
    chk({nm, " req"}, {30'd0, dmemREN, dmemWEN}, 32'd0);
    chk({nm, " load_valid"}, {31'd0, load_valid}, 32'd0);
    @(posedge CLK); #1;
    clear_inputs();
  endtask

  task automatic check_all_zero(input string nm);
    chk({nm, " stall"}, {31'd0, mem_stall}, 32'd0);
    chk({nm, " req"}, {30'd0, dmemREN, dmemWEN}, 32'd0);
    chk({nm, " addr"}, dmemaddr, 32'd0);
    chk({nm, " store"}, dmemstore, 32'd0);
    chk({nm, " load_out"}, load_out, 32'd0);
    chk({nm, " flags"}, {29'd0, load_valid, sc_result, err_out}, 32'd0);
  endtask

  logic        r_rd, r_wr, r_ll, r_sc, is_r, is_sc, sc_ok, to_m, xlv_m, xsc_m, nz;
  logic [31:0] a_m, d_m, rd_m, xlo_m;
  int          ty, hd_m, xs_m;

  initial begin
    clear_inputs();
    RST = 1;
    m_err = 0; m_link_v = 0; m_link_a = '0;
    @(posedge CLK);
    @(negedge CLK);
    check_all_zero("reset");
    @(posedge CLK); #1;
    RST = 0;

    //                 rd wr ll sc addr          data          hd  rdata         xs lv lo            sc
    tbl.push_back(mkv(1, 0, 0, 0, 32'h100, 32'h0,        0,  32'hDEADBEEF, 2, 1, 32'hDEADBEEF, 0));
    tbl.push_back(mkv(0, 1, 0, 0, 32'h200, 32'h12345678, 3,  32'h0,        5, 0, 32'h0,        0));
    tbl.push_back(mkv(1, 0, 1, 0, 32'h300, 32'h0,        1,  32'hCAFE0000, 3, 1, 32'hCAFE0000, 0));
    tbl.push_back(mkv(0, 1, 0, 1, 32'h300, 32'h1,        0,  32'h0,        2, 1, 32'h1,        1));
    tbl.push_back(mkv(0, 1, 0, 1, 32'h300, 32'h1,        0,  32'h0,        1, 1, 32'h0,        0));
    tbl.push_back(mkv(1, 0, 1, 0, 32'h300, 32'h0,        0,  32'h11,       2, 1, 32'h11,       0));
    tbl.push_back(mkv(0, 1, 0, 0, 32'h300, 32'h5,        0,  32'h0,        2, 0, 32'h0,        0));
    tbl.push_back(mkv(0, 1, 0, 1, 32'h300, 32'h1,        0,  32'h0,        1, 1, 32'h0,        0));
    tbl.push_back(mkv(1, 0, 1, 0, 32'h300, 32'h0,        0,  32'h22,       2, 1, 32'h22,       0));
    tbl.push_back(mkv(0, 1, 0, 0, 32'h304, 32'h6,        0,  32'h0,        2, 0, 32'h0,        0));
    tbl.push_back(mkv(0, 1, 0, 1, 32'h300, 32'h1,        2,  32'h0,        4, 1, 32'h1,        1));
    tbl.push_back(mkv(1, 1, 0, 0, 32'h400, 32'hA5A5,     0,  32'hFFFF,     2, 0, 32'h0,        0));
    tbl.push_back(mkv(0, 1, 1, 0, 32'h500, 32'h7,        0,  32'h0,        2, 0, 32'h0,        0));
    tbl.push_back(mkv(0, 1, 0, 1, 32'h500, 32'h1,        0,  32'h0,        1, 1, 32'h0,        0));
    tbl.push_back(mkv(1, 0, 0, 0, 32'h600, 32'h0,        99, 32'h44,       5, 1, 32'h0,        0));
    tbl.push_back(mkv(1, 0, 0, 0, 32'h604, 32'h0,        0,  32'h77,       2, 1, 32'h77,       0));
    tbl.push_back(mkv(1, 0, 1, 0, 32'h700, 32'h0,        0,  32'h33,       2, 1, 32'h33,       0));
    tbl.push_back(mkv(0, 1, 0, 1, 32'h700, 32'h9,        99, 32'h0,        5, 1, 32'h0,        0));
    tbl.push_back(mkv(0, 1, 0, 1, 32'h700, 32'h9,        0,  32'h0,        2, 1, 32'h1,        1));
    tbl.push_back(mkv(0, 1, 0, 1, 32'h700, 32'h9,        0,  32'h0,        1, 1, 32'h0,        0));

    foreach (tbl[i])
      do_op(tbl[i].rd, tbl[i].wr, tbl[i].ll, tbl[i].sc, tbl[i].addr, tbl[i].data, tbl[i].hd,
            tbl[i].rdata, tbl[i].xs, tbl[i].xlv, tbl[i].xlo, tbl[i].xsc, (i % 2) == 1,
            $sformatf("vec%0d", i));

    idle_check(1'b0, 1'b1, 1'b0, "no valid");
    idle_check(1'b1, 1'b0, 1'b0, "no op");

    // reset in the middle of a request: nothing delivered, link and err cleared
    do_op(1, 0, 1, 0, 32'h800, 0, 0, 32'h55, 2, 1, 32'h55, 0, 0, "ll800");
    mem_valid = 1; dren_in = 1; addr_in = 32'h900; dmemload = 32'hBAD;
    @(negedge CLK);
    chk("rstseq accept stall", {31'd0, mem_stall}, 32'd1);
    @(posedge CLK); #1;
    RST = 1;
    @(negedge CLK);
    chk("rstseq req ren", {31'd0, dmemREN}, 32'd1);
    @(posedge CLK); #1;
    RST = 0; m_err = 0; m_link_v = 0;
    clear_inputs();
    dhit = 1; dmemload = 32'hBAD;
    @(negedge CLK);
    check_all_zero("rstseq after");
    @(posedge CLK); #1;
    dhit = 0;
    @(negedge CLK);
    check_all_zero("rstseq late dhit");
    @(posedge CLK); #1;
    do_op(0, 1, 0, 1, 32'h800, 32'h1, 0, 0, 1, 1, 32'h0, 0, 0, "sc800 after rst");

    for (int i = 0; i < 150; i++) begin
      ty = $urandom_range(0, 5);
      r_rd = 0; r_wr = 0; r_ll = 0; r_sc = 0;
      case (ty)
        0: begin r_rd = 1; r_sc = 1'($urandom_range(0, 1)); end
        1: begin r_wr = 1; r_ll = 1'($urandom_range(0, 1)); end
        2: begin r_rd = 1; r_ll = 1; end
        3: begin r_wr = 1; r_sc = 1; end
        4: begin r_rd = 1; r_wr = 1; end
        default: ;
      endcase
      a_m  = 32'h1000 + 32'($urandom_range(0, 2) * 4) + 32'($urandom_range(0, 3));
      d_m  = $urandom;
      rd_m = $urandom;
      hd_m = $urandom_range(0, 5);
      nz   = 1'($urandom_range(0, 1));
      if (ty == 5) begin
        idle_check(1'($urandom_range(0, 1)), 1'b0, 1'b0, $sformatf("rnd%0d idle", i));
      end else begin
        is_r  = r_rd & ~r_wr;
        is_sc = r_sc & r_wr;
        sc_ok = m_link_v && (m_link_a == a_m[31:2]);
        if (is_sc && !sc_ok) begin
          to_m = 0; xs_m = 1; xlv_m = 1; xlo_m = 0; xsc_m = 0;
        end else begin
          to_m  = (hd_m >= MW);
          xs_m  = to_m ? MW + 1 : hd_m + 2;
          xlv_m = is_r | is_sc;
          xlo_m = to_m ? 32'd0 : (is_sc ? 32'd1 : (is_r ? rd_m : 32'd0));
          xsc_m = !to_m && is_sc;
        end
        do_op(r_rd, r_wr, r_ll, r_sc, a_m, d_m, hd_m, rd_m, xs_m, xlv_m, xlo_m, xsc_m, nz,
              $sformatf("rnd%0d", i));
        if (is_sc) begin
          if (!sc_ok || !to_m) m_link_v = 0;
        end else if (r_ll && is_r && !to_m) begin
          m_link_v = 1; m_link_a = a_m[31:2];
        end else if (r_wr && !to_m && m_link_v && m_link_a == a_m[31:2]) begin
          m_link_v = 0;
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
